// File: rtl/nubus_mem_arbiter.sv
// Shares one memory target between NuBus slave (A) and CPU (B); grant registered, 1 cycle after request.
// Requesters are stalled via x_ready until m_ready or timeout; one idle cycle separates transactions.
module nubus_mem_arbiter #(
  parameter int TIMEOUT_CLKS = 16
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic        a_valid,
  input  logic [3:0]  a_wstrb,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_ready,
  output logic        a_error,
  input  logic        b_valid,
  input  logic [3:0]  b_wstrb,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_ready,
  output logic        b_error,
  output logic        m_valid,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, RELEASE} state_t;

  localparam int          TO_M1   = (TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1;
  localparam logic [7:0]  TO_LAST = TO_M1[7:0];

  state_t      r_state;
  state_t      w_next;
  logic        r_last_b;
  logic        w_next_last_b;
  logic [7:0]  r_cnt;

  logic        w_busy;
  logic        w_sel_b;
  logic        w_x_valid;
  logic        w_to_hit;
  logic        w_ready;
  logic        w_error;

  assign w_busy    = (r_state == BUSY_A) || (r_state == BUSY_B);
  assign w_sel_b   = (r_state == BUSY_B);
  assign w_x_valid = w_sel_b ? b_valid : a_valid;
  assign w_to_hit  = (TIMEOUT_CLKS != 0) && (r_cnt == TO_LAST);

  // Abort beats completion beats timeout; an aborting requester never sees ready.
  assign w_ready = w_busy && w_x_valid && (m_ready || w_to_hit);
  assign w_error = w_busy && w_x_valid && !m_ready && w_to_hit;

  function automatic state_t arbitrate(input logic av, input logic bv, input logic last_b);
    if (av && bv)
      return last_b ? BUSY_A : BUSY_B;
    else if (av)
      return BUSY_A;
    else if (bv)
      return BUSY_B;
    else
      return IDLE;
  endfunction

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      r_state  <= IDLE;
      r_last_b <= 1'b1;
      r_cnt    <= 8'd0;
    end else begin
      r_state  <= w_next;
      r_last_b <= w_next_last_b;
      if (!w_busy)
        r_cnt <= 8'd0;
      else if (r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_next_last_b = r_last_b;
    case (r_state)
      IDLE, RELEASE: w_next = arbitrate(a_valid, b_valid, r_last_b);
      BUSY_A, BUSY_B: begin
        if (!w_x_valid || m_ready || w_to_hit) begin
          w_next        = RELEASE;
          w_next_last_b = w_sel_b;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    m_valid = w_busy;
    m_wstrb = 4'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    grant_o = 2'b00;
    a_rdata = 32'd0;
    a_ready = 1'b0;
    a_error = 1'b0;
    b_rdata = 32'd0;
    b_ready = 1'b0;
    b_error = 1'b0;
    if (r_state == BUSY_A) begin
      m_wstrb = a_wstrb;
      m_addr  = a_addr;
      m_wdata = a_wdata;
      grant_o = 2'b01;
      a_rdata = m_rdata;
      a_ready = w_ready;
      a_error = w_error;
    end else if (r_state == BUSY_B) begin
      m_wstrb = b_wstrb;
      m_addr  = b_addr;
      m_wdata = b_wdata;
      grant_o = 2'b10;
      b_rdata = m_rdata;
      b_ready = w_ready;
      b_error = w_error;
    end
  end

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Cycle-by-cycle directed table against a small wait-state memory model, plus a reset-mid-transaction sequence.
module tb_nubus_mem_arbiter;

  logic        mem_clk;
  logic        mem_reset;
  logic        a_valid, b_valid;
  logic [3:0]  a_wstrb, b_wstrb;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, a_error, b_ready, b_error;
  logic        m_valid;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ready;
  logic [1:0]  grant_o;

  nubus_mem_arbiter #(.TIMEOUT_CLKS(4)) dut (
    .mem_clk(mem_clk), .mem_reset(mem_reset),
    .a_valid(a_valid), .a_wstrb(a_wstrb), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ready(a_ready), .a_error(a_error),
    .b_valid(b_valid), .b_wstrb(b_wstrb), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ready(b_ready), .b_error(b_error),
    .m_valid(m_valid), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .grant_o(grant_o)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Memory model: acks after wt wait cycles of m_valid; counter restarts when valid drops.
  logic [31:0] mem [16];
  int          wcnt;
  int          wt;
  logic        stall;

  assign m_ready = m_valid && !stall && (wcnt == wt);
  assign m_rdata = m_ready ? mem[m_addr[5:2]] : 32'd0;

  always @(posedge mem_clk) begin
    if (!m_valid || m_ready)
      wcnt <= 0;
    else
      wcnt <= wcnt + 1;
    if (m_ready) begin
      for (int i = 0; i < 4; i++)
        if (m_wstrb[i]) mem[m_addr[5:2]][i*8 +: 8] <= m_wdata[i*8 +: 8];
    end
  end

  typedef struct {
    logic        rst;
    int          ph;
    logic        av, bv;
    int          wt;
    logic        st;
    logic        mv;
    logic [1:0]  g;
    logic        ar, ae, br, be;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  logic [3:0]  pa_s[3], pb_s[3];
  logic [31:0] pa_a[3], pb_a[3], pa_d[3], pb_d[3];

  int total = 0;
  int bad   = 0;
  int cur_row;

  function automatic vec_t r(input logic rst, input int ph, input logic av, input logic bv,
                             input int w, input logic st, input logic mv, input logic [1:0] g,
                             input logic ar, input logic ae, input logic br, input logic be,
                             input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.ph = ph; v.av = av; v.bv = bv; v.wt = w; v.st = st;
    v.mv = mv; v.g = g; v.ar = ar; v.ae = ae; v.br = br; v.be = be; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, cur_row, act, exp);
    end
  endtask

  task automatic drive_payload(input int ph);
    a_wstrb = pa_s[ph]; a_addr = pa_a[ph]; a_wdata = pa_d[ph];
    b_wstrb = pb_s[ph]; b_addr = pb_a[ph]; b_wdata = pb_d[ph];
  endtask

  initial begin
    logic [3:0]  e_s;
    logic [31:0] e_a, e_d;

    // ph0: reads; ph1: A full write, B partial write; ph2: A reads back B's partial write
    pa_s[0] = 4'h0; pa_a[0] = 32'h10; pa_d[0] = 32'h0;
    pb_s[0] = 4'h0; pb_a[0] = 32'h14; pb_d[0] = 32'h0;
    pa_s[1] = 4'hF; pa_a[1] = 32'h20; pa_d[1] = 32'h11111111;
    pb_s[1] = 4'h3; pb_a[1] = 32'h24; pb_d[1] = 32'h22222222;
    pa_s[2] = 4'h0; pa_a[2] = 32'h24; pa_d[2] = 32'h0;
    pb_s[2] = 4'h0; pb_a[2] = 32'h14; pb_d[2] = 32'h0;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[5] = 32'h5555AAAA;
    mem[8] = 32'h12345678;
    mem[9] = 32'hAAAAAAAA;

    // reset + single A read, zero wait
    tbl.push_back(r(1,0,0,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,1,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,1,0,0,0, 1,2'b01, 1,0,0,0, 32'hDEADBEEF));
    tbl.push_back(r(0,0,0,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,0,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    // reset, then simultaneous writes with 2 wait states: A first
    tbl.push_back(r(1,1,0,0,2,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,2,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,2,0, 1,2'b01, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,2,0, 1,2'b01, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,2,0, 1,2'b01, 1,0,0,0, 32'h12345678));
    tbl.push_back(r(0,1,0,1,2,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,0,1,2,0, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,0,1,2,0, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,0,1,2,0, 1,2'b10, 0,0,1,0, 32'hAAAAAAAA));
    tbl.push_back(r(0,1,0,0,2,0, 0,2'b00, 0,0,0,0, 32'h0));
    // alternation under constant contention
    tbl.push_back(r(0,0,1,1,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,1,1,0,0, 1,2'b01, 1,0,0,0, 32'hDEADBEEF));
    tbl.push_back(r(0,0,0,1,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,1,1,0,0, 1,2'b10, 0,0,1,0, 32'h5555AAAA));
    tbl.push_back(r(0,0,1,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,1,1,0,0, 1,2'b01, 1,0,0,0, 32'hDEADBEEF));
    tbl.push_back(r(0,0,0,1,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,1,1,0,0, 1,2'b10, 0,0,1,0, 32'h5555AAAA));
    tbl.push_back(r(0,0,0,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    // timeout on B with memory stalled
    tbl.push_back(r(0,0,0,1,0,1, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,0,1,0,1, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,0,1,0,1, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,0,1,0,1, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,0,1,0,1, 1,2'b10, 0,0,1,1, 32'h0));
    tbl.push_back(r(0,0,0,0,0,1, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,0,0,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    // A aborts in 2nd busy cycle, re-requests in RELEASE: tie goes to B
    tbl.push_back(r(0,1,1,1,3,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,3,0, 1,2'b01, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,0,1,3,0, 1,2'b01, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,3,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,3,0, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,3,0, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,3,0, 1,2'b10, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,1,1,1,3,0, 1,2'b10, 0,0,1,0, 32'hAAAA2222));
    tbl.push_back(r(0,2,1,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));
    tbl.push_back(r(0,2,1,0,0,0, 1,2'b01, 1,0,0,0, 32'hAAAA2222));
    tbl.push_back(r(0,2,0,0,0,0, 0,2'b00, 0,0,0,0, 32'h0));

    mem_reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    wt = 0; stall = 1'b0;
    drive_payload(0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge mem_clk);
      cur_row   = k;
      mem_reset = tbl[k].rst;
      a_valid   = tbl[k].av;
      b_valid   = tbl[k].bv;
      wt        = tbl[k].wt;
      stall     = tbl[k].st;
      drive_payload(tbl[k].ph);
      #1;
      e_s = 4'h0; e_a = 32'h0; e_d = 32'h0;
      if (tbl[k].g == 2'b01) begin
        e_s = pa_s[tbl[k].ph]; e_a = pa_a[tbl[k].ph]; e_d = pa_d[tbl[k].ph];
      end else if (tbl[k].g == 2'b10) begin
        e_s = pb_s[tbl[k].ph]; e_a = pb_a[tbl[k].ph]; e_d = pb_d[tbl[k].ph];
      end
      chk("m_valid", {31'd0, m_valid}, {31'd0, tbl[k].mv});
      chk("grant_o", {30'd0, grant_o}, {30'd0, tbl[k].g});
      chk("a_ready", {31'd0, a_ready}, {31'd0, tbl[k].ar});
      chk("a_error", {31'd0, a_error}, {31'd0, tbl[k].ae});
      chk("b_ready", {31'd0, b_ready}, {31'd0, tbl[k].br});
      chk("b_error", {31'd0, b_error}, {31'd0, tbl[k].be});
      chk("a_rdata", a_rdata, tbl[k].ar ? tbl[k].rd : 32'h0);
      chk("b_rdata", b_rdata, tbl[k].br ? tbl[k].rd : 32'h0);
      chk("m_wstrb", {28'd0, m_wstrb}, {28'd0, e_s});
      chk("m_addr",  m_addr,  e_a);
      chk("m_wdata", m_wdata, e_d);
    end

    // reset asserted mid BUSY_B: outputs must drop before any clock edge
    cur_row = 1000;
    @(negedge mem_clk);
    drive_payload(0);
    wt = 3; stall = 1'b0;
    b_valid = 1'b1;
    @(posedge mem_clk);
    @(negedge mem_clk);
    #1;
    chk("busy_b grant", {30'd0, grant_o}, 32'd2);
    chk("busy_b m_valid", {31'd0, m_valid}, 32'd1);
    mem_reset = 1'b1;
    #1;
    chk("async m_valid", {31'd0, m_valid}, 32'd0);
    chk("async grant_o", {30'd0, grant_o}, 32'd0);
    chk("async b_ready", {31'd0, b_ready}, 32'd0);
    chk("async m_addr", m_addr, 32'd0);
    @(negedge mem_clk);
    mem_reset = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("post reset idle", {30'd0, grant_o}, 32'd0);
    @(negedge mem_clk);
    #1;
    chk("post reset tie A", {30'd0, grant_o}, 32'd1);
    chk("post reset m_addr", m_addr, 32'h10);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge mem_clk);
    @(negedge mem_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
